// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: funct3 codes, FSM encoding and access-size decode shared by the memory stage
package mem_access_unit_pkg;
  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;
  function automatic logic is_byte(input logic [2:0] f3);
    return f3 == MEM_B || f3 == MEM_BU;
  endfunction
  function automatic logic is_half(input logic [2:0] f3);
    return f3 == MEM_H || f3 == MEM_HU;
  endfunction
  function automatic logic is_unsigned(input logic [2:0] f3);
    return f3 == MEM_BU || f3 == MEM_HU;
  endfunction
endpackage

// File: rtl/mem_align.sv
// mem_align: store lane replication/byte enables, load extraction and misalignment check
// Ports: st_f3/st_lo/st_data -> st_wdata, st_be, misaligned (store side and check, from the live instruction);
//        ld_f3/ld_lo/rdata -> ld_data (load side, from the launch-registered funct3 and address bits).
// Anything that is not B/BU/H/HU is handled as a word access.
module mem_align
  import mem_access_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      st_f3,
  input  logic [1:0]      st_lo,
  input  logic [XLEN-1:0] st_data,
  output logic [XLEN-1:0] st_wdata,
  output logic [3:0]      st_be,
  output logic            misaligned,
  input  logic [2:0]      ld_f3,
  input  logic [1:0]      ld_lo,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] ld_data
);
  logic [XLEN-1:0] w;
  logic            sx;
  always_comb begin
    st_wdata   = is_byte(st_f3) ? {(XLEN/8){st_data[7:0]}} :
                 is_half(st_f3) ? {(XLEN/16){st_data[15:0]}} : st_data;
    st_be      = is_byte(st_f3) ? 4'b0001 << st_lo :
                 is_half(st_f3) ? 4'b0011 << st_lo : 4'b1111;
    misaligned = is_byte(st_f3) ? 1'b0 : is_half(st_f3) ? st_lo[0] : |st_lo;
    w          = rdata >> {ld_lo, 3'b000};
    sx         = !is_unsigned(ld_f3);
    ld_data    = is_byte(ld_f3) ? {{(XLEN-8){sx & w[7]}}, w[7:0]} :
                 is_half(ld_f3) ? {{(XLEN-16){sx & w[15]}}, w[15:0]} : w;
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory stage issuing aligned loads/stores over a req/ack port with stall, misalignment and watchdog fault
// Ports: ID_memread/ID_memwrite/ID_memfunct3, EX_result (address), reg_read_data_2 (store data) in;
//        MEM_stall, MEM_valid, MEM_read_data, MEM_misaligned, MEM_fault to the pipeline;
//        dmem_req/we/addr/wdata/be out and dmem_rdata/dmem_ack in on the data-memory port.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ID_memread,
  input  logic            ID_memwrite,
  input  logic [2:0]      ID_memfunct3,
  input  logic [XLEN-1:0] EX_result,
  input  logic [XLEN-1:0] reg_read_data_2,
  output logic            MEM_stall,
  output logic            MEM_valid,
  output logic [XLEN-1:0] MEM_read_data,
  output logic            MEM_misaligned,
  output logic            MEM_fault,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_ack
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] EXPIRE = CW'(TIMEOUT_CYCLES - 1);
  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      f3_q;
  logic [1:0]      lo_q;
  logic [XLEN-1:0] st_wdata, ld_data;
  logic [3:0]      st_be;
  logic            mis, access, launch;
  mem_align #(.XLEN(XLEN)) u_align (
    .st_f3      (ID_memfunct3),
    .st_lo      (EX_result[1:0]),
    .st_data    (reg_read_data_2),
    .st_wdata   (st_wdata),
    .st_be      (st_be),
    .misaligned (mis),
    .ld_f3      (f3_q),
    .ld_lo      (lo_q),
    .rdata      (dmem_rdata),
    .ld_data    (ld_data)
  );
  assign access         = ID_memread | ID_memwrite;
  assign launch         = state == IDLE && access && !mis;
  assign MEM_misaligned = state == IDLE && access && mis;
  assign MEM_stall      = launch || state == REQ;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      f3_q          <= '0;
      lo_q          <= '0;
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_wdata    <= '0;
      dmem_be       <= '0;
      MEM_read_data <= '0;
      MEM_valid     <= 1'b0;
      MEM_fault     <= 1'b0;
    end else begin
      MEM_valid <= 1'b0;
      MEM_fault <= 1'b0;
      case (state)
        IDLE: if (launch) begin
          state      <= REQ;
          dmem_req   <= 1'b1;
          dmem_we    <= ID_memwrite;
          dmem_addr  <= {EX_result[XLEN-1:2], 2'b00};
          dmem_wdata <= st_wdata;
          dmem_be    <= st_be;
          f3_q       <= ID_memfunct3;
          lo_q       <= EX_result[1:0];
          cnt        <= '0;
        end
        REQ: if (dmem_ack) begin
          dmem_req  <= 1'b0;
          state     <= DONE;
          MEM_valid <= 1'b1;
          if (!dmem_we) MEM_read_data <= ld_data;
        end else if (cnt == EXPIRE) begin
          dmem_req      <= 1'b0;
          state         <= DONE;
          MEM_valid     <= 1'b1;
          MEM_fault     <= 1'b1;
          MEM_read_data <= '0;
        end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed self-checking bench for mem_access_unit
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;
  logic        clk = 0, rst = 1;
  logic        ID_memread = 0, ID_memwrite = 0;
  logic [2:0]  ID_memfunct3 = 0;
  logic [31:0] EX_result = 0, reg_read_data_2 = 0, dmem_rdata = 0;
  logic        dmem_ack = 0;
  logic        MEM_stall, MEM_valid, MEM_misaligned, MEM_fault, dmem_req, dmem_we;
  logic [31:0] MEM_read_data, dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  int          n_tests = 0, n_fail = 0;
  int          o_stalls, o_reqs;
  logic        o_valid, o_fault, o_we, o_mis;
  logic [31:0] o_rd, o_addr, o_wdata;
  logic [3:0]  o_be;
  int          vcnt;
  mem_access_unit dut (
    .clk(clk), .rst(rst),
    .ID_memread(ID_memread), .ID_memwrite(ID_memwrite), .ID_memfunct3(ID_memfunct3),
    .EX_result(EX_result), .reg_read_data_2(reg_read_data_2),
    .MEM_stall(MEM_stall), .MEM_valid(MEM_valid), .MEM_read_data(MEM_read_data),
    .MEM_misaligned(MEM_misaligned), .MEM_fault(MEM_fault),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // ack_at: REQ cycle (1-based) on which dmem_ack is returned, 0 = never
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] d, input int ack_at, input logic [31:0] rdata);
    @(posedge clk); #1;
    ID_memread = rd; ID_memwrite = wr; ID_memfunct3 = f3; EX_result = addr; reg_read_data_2 = d;
    o_stalls = 0; o_reqs = 0; o_valid = 0; o_fault = 0; o_rd = 0; o_mis = 0;
    for (int c = 0; c < 40 && !o_valid; c++) begin
      @(negedge clk);
      if (c == 0) o_mis = MEM_misaligned;
      if (MEM_stall) o_stalls++;
      if (dmem_req) begin
        o_reqs++;
        if (o_reqs == 1) begin o_addr = dmem_addr; o_we = dmem_we; o_be = dmem_be; o_wdata = dmem_wdata; end
      end
      if (MEM_valid) begin o_valid = 1; o_fault = MEM_fault; o_rd = MEM_read_data; end
      dmem_ack = dmem_req && o_reqs == ack_at;
      dmem_rdata = rdata;
    end
    @(posedge clk); #1;
    ID_memread = 0; ID_memwrite = 0; dmem_ack = 0;
  endtask
  initial begin
    #12;
    check("rst_req", dmem_req, 0);
    check("rst_valid", MEM_valid, 0);
    check("rst_rdata", MEM_read_data, 0);
    check("rst_addr", dmem_addr, 0);
    check("rst_be", dmem_be, 0);
    check("rst_stall", MEM_stall, 0);
    @(negedge clk); rst = 0;
    access(1, 0, MEM_W, 32'h100, 0, 2, 32'hDEADBEEF);
    check("lw_addr", o_addr, 32'h100);
    check("lw_we", o_we, 0);
    check("lw_stalls", o_stalls, 3);
    check("lw_valid", o_valid, 1);
    check("lw_data", o_rd, 32'hDEADBEEF);
    check("lw_fault", o_fault, 0);
    @(negedge clk);
    check("lw_valid_pulse", MEM_valid, 0);
    access(1, 0, MEM_B, 32'h103, 0, 1, 32'h80FFFFFF);
    check("lb_addr", o_addr, 32'h100);
    check("lb_data", o_rd, 32'hFFFFFF80);
    access(1, 0, MEM_BU, 32'h103, 0, 1, 32'h80FFFFFF);
    check("lbu_data", o_rd, 32'h00000080);
    access(1, 0, MEM_HU, 32'h102, 0, 1, 32'hBEEF1234);
    check("lhu_data", o_rd, 32'h0000BEEF);
    access(1, 0, MEM_H, 32'h102, 0, 1, 32'hBEEF1234);
    check("lh_data", o_rd, 32'hFFFFBEEF);
    access(0, 1, MEM_B, 32'h201, 32'h000000AB, 1, 32'h55555555);
    check("sb_we", o_we, 1);
    check("sb_addr", o_addr, 32'h200);
    check("sb_be", o_be, 4'b0010);
    check("sb_wdata", o_wdata, 32'hABABABAB);
    check("sb_rdata_kept", o_rd, 32'hFFFFBEEF);
    access(0, 1, MEM_H, 32'h202, 32'h00001234, 1, 0);
    check("sh_be", o_be, 4'b1100);
    check("sh_wdata", o_wdata, 32'h12341234);
    access(1, 1, MEM_W, 32'h204, 32'hCAFEF00D, 1, 0);
    check("rw_is_store", o_we, 1);
    check("sw_be", o_be, 4'b1111);
    check("sw_wdata", o_wdata, 32'hCAFEF00D);
    access(1, 0, MEM_W, 32'h102, 0, 1, 0);
    check("mis_flag", o_mis, 1);
    check("mis_reqs", o_reqs, 0);
    check("mis_stalls", o_stalls, 0);
    check("mis_valid", o_valid, 0);
    access(1, 0, MEM_H, 32'h101, 0, 1, 0);
    check("mis_h_flag", o_mis, 1);
    check("mis_h_reqs", o_reqs, 0);
    access(1, 0, MEM_W, 32'h400, 0, 0, 32'h11111111);
    check("to_reqs", o_reqs, 16);
    check("to_stalls", o_stalls, 17);
    check("to_valid", o_valid, 1);
    check("to_fault", o_fault, 1);
    check("to_data", o_rd, 0);
    @(negedge clk);
    check("to_fault_pulse", MEM_fault, 0);
    access(1, 0, MEM_W, 32'h400, 0, 16, 32'h22222222);
    check("to_ack16_reqs", o_reqs, 16);
    check("to_ack16_fault", o_fault, 0);
    check("to_ack16_data", o_rd, 32'h22222222);
    @(posedge clk); #1;
    ID_memread = 1; ID_memfunct3 = MEM_W; EX_result = 32'h300;
    repeat (3) @(negedge clk);
    check("rst_pre_req", dmem_req, 1);
    #2 rst = 1;
    #1 check("rst_async_req", dmem_req, 0);
    ID_memread = 0;
    #1 check("rst_mid_stall", MEM_stall, 0);
    @(negedge clk); rst = 0;
    vcnt = 0;
    repeat (4) begin @(negedge clk); vcnt += int'(MEM_valid) + int'(dmem_req); end
    check("rst_no_valid", vcnt, 0);
    @(posedge clk); #1 dmem_ack = 1; dmem_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1 dmem_ack = 0;
    vcnt = 0;
    repeat (3) begin @(negedge clk); vcnt += int'(MEM_valid) + int'(dmem_req) + int'(MEM_stall); end
    check("spurious_ack", vcnt, 0);
    check("spurious_rdata", MEM_read_data, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
